// File: rtl/controlador_patching_if.sv
// Bundle of the stream-in, stream-out and patching-datapath signals of controlador_patching.
// slave is the controller side; master is the side that feeds vectors and hosts the datapath.
interface controlador_patching_if #(
  parameter int N = 16,
  parameter int M = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a_in     [M-1:0];
  logic [N-1:0] thresh;
  logic         flush;
  logic [N-1:0] a_org    [M-1:0];
  logic [N-1:0] a_cache  [M-1:0];
  logic [M-1:0] p;
  logic [N-1:0] b        [M-1:0];
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data [M-1:0];

  modport master (
    output in_valid, a_in, thresh, flush, b, out_ready,
    input  in_ready, a_org, a_cache, p, out_valid, out_data
  );

  modport slave (
    input  in_valid, a_in, thresh, flush, b, out_ready,
    output in_ready, a_org, a_cache, p, out_valid, out_data
  );
endinterface

// File: rtl/controlador_patching.sv
// Activation-patching controller: compares each vector with a cached copy and drives patch bits.
// Optional PATCH_STATS_EN adds a saturating 32-bit count of patched lanes.
module controlador_patching #(
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  controlador_patching_if.slave bus
`ifdef PATCH_STATS_EN
  ,
  output logic [31:0]           patched_count
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMP, ST_ISSUE, ST_OUT} state_e;

  state_e       state_q;
  logic [N-1:0] a_org_q    [M-1:0];
  logic [N-1:0] a_cache_q  [M-1:0];
  logic [N-1:0] out_data_q [M-1:0];
  logic [N-1:0] thresh_q;
  logic [M-1:0] p_q;
  logic [M-1:0] p_d;
  logic         cache_valid_q;
  logic         out_valid_q;
  logic         in_ready_q;
  logic         out_hs;
  logic [N:0]   diff;

  assign out_hs = (state_q == ST_OUT) && out_valid_q && bus.out_ready;

  // A flush seen during CMP already counts as an invalid cache for this vector.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    p_d  = '0;
    diff = '0;
    for (int i = 0; i < M; i++) begin
      if (a_org_q[i] >= a_cache_q[i]) diff = {1'b0, a_org_q[i]} - {1'b0, a_cache_q[i]};
      else                            diff = {1'b0, a_cache_q[i]} - {1'b0, a_org_q[i]};
      p_d[i] = cache_valid_q && !bus.flush && (diff <= {1'b0, thresh_q});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      cache_valid_q <= 1'b0;
      p_q           <= '0;
      thresh_q      <= '0;
      // NOTE: the lane registers are reset as well because they drive visible outputs.
      for (int i = 0; i < M; i++) begin
        a_org_q[i]    <= '0;
        a_cache_q[i]  <= '0;
        out_data_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
      cache_valid_q <= (cache_valid_q | out_hs) & ~bus.flush;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_org_q    <= bus.a_in;
            thresh_q   <= bus.thresh;
            p_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_CMP;
          end
        end
        ST_CMP: begin
          p_q     <= p_d;
          state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          out_data_q  <= bus.b;
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_hs) begin
            for (int i = 0; i < M; i++) begin
              if (!p_q[i]) a_cache_q[i] <= a_org_q[i];
            end
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            p_q         <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.a_org     = a_org_q;
  assign bus.a_cache   = a_cache_q;
  assign bus.p         = p_q;

`ifdef PATCH_STATS_EN
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [32:0] sum;

  always_comb begin
    sum = {1'b0, cnt_q};
    for (int i = 0; i < M; i++) sum = sum + 33'(p_q[i]);
    cnt_d = sum[32] ? '1 : sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) cnt_q <= '0;
    else if (out_hs)      cnt_q <= cnt_d;
  end

  assign patched_count = cnt_q;
`endif

endmodule

// File: tb/tb_controlador_patching.sv
// Directed, table-driven bench for controlador_patching with a combinational patching datapath.
// Lanes alternate between an even-lane and an odd-lane value in every vector.
module tb_controlador_patching;
  localparam int N = 16;
  localparam int M = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  controlador_patching_if #(.N(N), .M(M)) bus ();
`ifdef PATCH_STATS_EN
  logic [31:0] patched_count;
`endif

  controlador_patching #(.N(N), .M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PATCH_STATS_EN
    ,
    .patched_count (patched_count)
`endif
  );

  // Patching datapath: patched lanes take the cached activation.
  always_comb begin
    for (int i = 0; i < M; i++) bus.b[i] = bus.p[i] ? bus.a_cache[i] : bus.a_org[i];
  end

  // mode: 0 plain, 1 flush during CMP, 2 flush coincident with the output handshake
  typedef struct {
    logic [N-1:0] ae, ao, thr;
    int           stall;
    int           mode;
    logic [M-1:0] ep;
    logic [N-1:0] eoe, eoo, ece, eco;
    logic [31:0]  ecnt;
  } vec_t;

  vec_t tbl [12];
  int checks   = 0;
  int failures = 0;
  logic [N-1:0] prev_ce = '0;
  logic [N-1:0] prev_co = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_lanes(input string nm, input logic [N-1:0] arr [M-1:0],
                             input logic [N-1:0] ee, input logic [N-1:0] eo);
    for (int i = 0; i < M; i++)
      check($sformatf("%s[%0d]", nm, i), 32'(arr[i]), 32'((i % 2 == 0) ? ee : eo));
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   budget;
    v = tbl[idx];
    budget = 0;
    while (!bus.in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check($sformatf("v%0d in_ready", idx), 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < M; i++) bus.a_in[i] = (i % 2 == 0) ? v.ae : v.ao;
    bus.thresh   = v.thr;
    bus.in_valid = 1'b1;
    @(negedge clk);  // T+1: CMP
    bus.in_valid = 1'b0;
    check($sformatf("v%0d cmp out_valid", idx), 32'(bus.out_valid), 32'd0);
    check($sformatf("v%0d cmp p", idx), 32'(bus.p), 32'd0);
    check($sformatf("v%0d cmp in_ready", idx), 32'(bus.in_ready), 32'd0);
    if (v.mode == 1) bus.flush = 1'b1;
    @(negedge clk);  // T+2: ISSUE
    bus.flush = 1'b0;
    check($sformatf("v%0d issue p", idx), 32'(bus.p), 32'(v.ep));
    check($sformatf("v%0d issue out_valid", idx), 32'(bus.out_valid), 32'd0);
    @(negedge clk);  // T+3: OUT
    check($sformatf("v%0d out_valid", idx), 32'(bus.out_valid), 32'd1);
    check_lanes($sformatf("v%0d out_data", idx), bus.out_data, v.eoe, v.eoo);
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      check($sformatf("v%0d stall%0d out_valid", idx, s), 32'(bus.out_valid), 32'd1);
      check($sformatf("v%0d stall%0d in_ready", idx, s), 32'(bus.in_ready), 32'd0);
      check($sformatf("v%0d stall%0d out_data0", idx, s), 32'(bus.out_data[0]), 32'(v.eoe));
      check($sformatf("v%0d stall%0d out_data1", idx, s), 32'(bus.out_data[1]), 32'(v.eoo));
      check($sformatf("v%0d stall%0d cache0", idx, s), 32'(bus.a_cache[0]), 32'(prev_ce));
      check($sformatf("v%0d stall%0d cache1", idx, s), 32'(bus.a_cache[1]), 32'(prev_co));
    end
    bus.out_ready = 1'b1;
    if (v.mode == 2) bus.flush = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    check($sformatf("v%0d post out_valid", idx), 32'(bus.out_valid), 32'd0);
    check($sformatf("v%0d post in_ready", idx), 32'(bus.in_ready), 32'd1);
    check($sformatf("v%0d post p", idx), 32'(bus.p), 32'd0);
    if (v.mode != 2) check_lanes($sformatf("v%0d a_cache", idx), bus.a_cache, v.ece, v.eco);
`ifdef PATCH_STATS_EN
    check($sformatf("v%0d patched_count", idx), patched_count, v.ecnt);
`endif
    prev_ce = v.ece;
    prev_co = v.eco;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            ae      ao      thr     stall mode ep        eoe     eoo    ece     eco    ecnt
    tbl[0]  = '{16'd100, 16'd100, 16'd5,    0, 0, 16'h0000, 16'd100, 16'd100, 16'd100, 16'd100, 32'd0};
    tbl[1]  = '{16'd103, 16'd110, 16'd5,    0, 0, 16'h5555, 16'd100, 16'd110, 16'd100, 16'd110, 32'd8};
    tbl[2]  = '{16'd100, 16'd110, 16'd0,    0, 0, 16'hFFFF, 16'd100, 16'd110, 16'd100, 16'd110, 32'd24};
    tbl[3]  = '{16'd101, 16'd109, 16'd0,    0, 0, 16'h0000, 16'd101, 16'd109, 16'd101, 16'd109, 32'd24};
    tbl[4]  = '{16'd0,   16'hFFFF, 16'hFFFF, 0, 0, 16'hFFFF, 16'd101, 16'd109, 16'd101, 16'd109, 32'd40};
    tbl[5]  = '{16'hFFFF, 16'd0,  16'd108,  0, 0, 16'h0000, 16'hFFFF, 16'd0, 16'hFFFF, 16'd0,   32'd40};
    tbl[6]  = '{16'd65530, 16'd5, 16'd4,   10, 0, 16'h0000, 16'd65530, 16'd5, 16'd65530, 16'd5,  32'd40};
    tbl[7]  = '{16'd7,   16'd7,   16'hFFFF, 0, 1, 16'h0000, 16'd7,   16'd7,   16'd7,   16'd7,   32'd0};
    tbl[8]  = '{16'd7,   16'd7,   16'hFFFF, 0, 0, 16'hFFFF, 16'd7,   16'd7,   16'd7,   16'd7,   32'd16};
    tbl[9]  = '{16'd9,   16'd9,   16'hFFFF, 0, 2, 16'hFFFF, 16'd7,   16'd7,   16'd0,   16'd0,   32'd0};
    tbl[10] = '{16'd9,   16'd9,   16'hFFFF, 0, 0, 16'h0000, 16'd9,   16'd9,   16'd9,   16'd9,   32'd0};
    tbl[11] = '{16'd7,   16'd7,   16'hFFFF, 0, 0, 16'h0000, 16'd7,   16'd7,   16'd7,   16'd7,   32'd0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.thresh    = '0;
    for (int i = 0; i < M; i++) bus.a_in[i] = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset p", 32'(bus.p), 32'd0);
    check_lanes("reset out_data", bus.out_data, '0, '0);
    check_lanes("reset a_org", bus.a_org, '0, '0);
    check_lanes("reset a_cache", bus.a_cache, '0, '0);
`ifdef PATCH_STATS_EN
    check("reset patched_count", patched_count, 32'd0);
`endif

    for (int k = 0; k < 11; k++) run_vec(k);

    // Reset pulsed while a vector sits in ISSUE: no output, cache invalidated.
    for (int i = 0; i < M; i++) bus.a_in[i] = 16'd50;
    bus.thresh   = 16'hFFFF;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_issue in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_issue out_valid", 32'(bus.out_valid), 32'd0);
    check_lanes("rst_issue a_cache", bus.a_cache, '0, '0);
    check_lanes("rst_issue out_data", bus.out_data, '0, '0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("rst_issue idle%0d out_valid", c), 32'(bus.out_valid), 32'd0);
    end
    prev_ce = '0;
    prev_co = '0;
    run_vec(11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
